// File: rtl/elastic_pipe_reg.sv
// Elastic pipeline register: DEPTH valid/ready stages with bubble collapse,
// global clock-enable, synchronous flush and synchronous active-high reset.
module elastic_pipe_reg #(
  parameter int              WIDTH     = 8,
  parameter int              DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       En,
  input  logic                       FLUSH,
  input  logic                       IN_VALID,
  input  logic [WIDTH-1:0]           IN_DATA,
  output logic                       IN_READY,
  output logic                       OUT_VALID,
  output logic [WIDTH-1:0]           OUT_DATA,
  input  logic                       OUT_READY,
  output logic [$clog2(DEPTH+1)-1:0] OCC
);

  localparam int OCCW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][WIDTH-1:0] data;
  logic [DEPTH-1:0]            vld;
  logic [DEPTH-1:0]            acc;
  logic                        active;
  logic                        in_xfer;
  logic                        out_xfer;

  assign active = En & ~FLUSH;

  // A stage can take new contents if it is empty or its occupant moves on.
  always_comb begin
    acc = '0;
    acc[DEPTH-1] = ~vld[DEPTH-1] | OUT_READY;
    for (int i = DEPTH-2; i >= 0; i--) begin
      acc[i] = ~vld[i] | acc[i+1];
    end
  end

  assign IN_READY  = acc[0] & active;
  assign OUT_VALID = vld[DEPTH-1] & active;
  assign OUT_DATA  = data[DEPTH-1];
  assign in_xfer   = IN_VALID & IN_READY;
  assign out_xfer  = OUT_VALID & OUT_READY;

  always_ff @(posedge CLK) begin
    if (RST) begin
      vld  <= '0;
      data <= {DEPTH{RESET_VAL}};
      OCC  <= '0;
    end else if (En) begin
      if (FLUSH) begin
        vld  <= '0;
        data <= {DEPTH{RESET_VAL}};
        OCC  <= '0;
      end else begin
        if (acc[0]) begin
          data[0] <= IN_DATA;
          vld[0]  <= in_xfer;
        end
        for (int i = 1; i < DEPTH; i++) begin
          if (acc[i]) begin
            data[i] <= data[i-1];
            vld[i]  <= vld[i-1];
          end
        end
        if (in_xfer && !out_xfer) begin
          OCC <= OCC + OCCW'(1);
        end else if (out_xfer && !in_xfer) begin
          OCC <= OCC - OCCW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Bench for elastic_pipe_reg: directed scenarios plus random traffic, each cycle
// compared against a word-queue model of the pipe.
module tb_elastic_pipe_reg;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;

  logic             CLK;
  logic             RST;
  logic             En;
  logic             FLUSH;
  logic             IN_VALID;
  logic [WIDTH-1:0] IN_DATA;
  logic             IN_READY;
  logic             OUT_VALID;
  logic [WIDTH-1:0] OUT_DATA;
  logic             OUT_READY;
  logic [1:0]       OCC;

  elastic_pipe_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(8'h00)) dut (
    .CLK(CLK), .RST(RST), .En(En), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_DATA(IN_DATA), .IN_READY(IN_READY),
    .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA), .OUT_READY(OUT_READY),
    .OCC(OCC)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Each in-flight word with the stage index it currently sits in.
  typedef struct {
    logic [7:0] d;
    int         p;
  } word_t;

  word_t q[$];
  int    errors = 0;
  int    checks = 0;
  bit    last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Words advance one stage if the slot ahead is free after the older word moved.
  // Returns the lowest stage occupied afterwards (DEPTH if the pipe ends up empty).
  function automatic int advance(input bit pop, input bit commit);
    int lim;
    int np;
    int start;
    lim   = DEPTH;
    start = pop ? 1 : 0;
    for (int k = start; k < q.size(); k++) begin
      np  = (q[k].p + 1 < lim) ? q[k].p + 1 : q[k].p;
      lim = np;
      if (commit) q[k].p = np;
    end
    if (commit && pop) void'(q.pop_front());
    return lim;
  endfunction

  task automatic cycle(input bit do_chk);
    int lim;
    bit eir;
    bit eov;
    bit pop;
    @(negedge CLK);
    eov = En && !FLUSH && q.size() > 0 && q[0].p == DEPTH-1;
    pop = eov && OUT_READY;
    lim = advance(pop, 1'b0);
    eir = En && !FLUSH && lim > 0;
    if (do_chk) begin
      chk("in_ready", IN_READY, eir);
      chk("out_valid", OUT_VALID, eov);
      if (eov) chk("out_data", OUT_DATA, q[0].d);
      chk("occ", OCC, q.size());
    end
    last_acc = 1'b0;
    if (RST || (En && FLUSH)) begin
      q.delete();
    end else if (En) begin
      void'(advance(pop, 1'b1));
      if (IN_VALID && eir) begin
        q.push_back('{IN_DATA, 0});
        last_acc = 1'b1;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [7:0] stream[4];
    logic [7:0] bp[4];
    int         idx;
    stream = '{8'h11, 8'h22, 8'h33, 8'h44};
    bp     = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};

    // Reset held two cycles while upstream offers data.
    RST = 1'b1; En = 1'b1; FLUSH = 1'b0;
    IN_VALID = 1'b1; IN_DATA = 8'h77; OUT_READY = 1'b1;
    cycle(1'b0);
    cycle(1'b1);
    chk("rst_out_data", OUT_DATA, 8'h00);
    chk("rst_occ", OCC, 2'd0);
    chk("rst_out_valid", OUT_VALID, 1'b0);
    RST = 1'b0; IN_VALID = 1'b0;
    cycle(1'b1);
    chk("post_rst_occ", OCC, 2'd0);

    // Streaming, back-to-back with the sink always ready.
    OUT_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      IN_VALID = 1'b1; IN_DATA = stream[i];
      cycle(1'b1);
      chk("stream_accept", last_acc, 1'b1);
    end
    IN_VALID = 1'b0;
    for (int i = 0; i < 5; i++) cycle(1'b1);
    chk("stream_empty", OCC, 2'd0);

    // Back-pressure: only three words fit.
    OUT_READY = 1'b0;
    idx = 0;
    for (int i = 0; i < 5; i++) begin
      IN_VALID = (idx < 4); IN_DATA = bp[idx < 4 ? idx : 3];
      cycle(1'b1);
      if (last_acc) idx++;
    end
    chk("bp_accepted", idx, 3);
    chk("bp_full_occ", OCC, 2'd3);
    chk("bp_in_ready", IN_READY, 1'b0);
    OUT_READY = 1'b1;
    for (int n = 0; n < 30 && !(idx == 4 && q.size() == 0); n++) begin
      IN_VALID = (idx < 4); IN_DATA = bp[idx < 4 ? idx : 3];
      cycle(1'b1);
      if (last_acc) idx++;
    end
    IN_VALID = 1'b0;
    chk("bp_all_sent", idx, 4);
    chk("bp_drained", OCC, 2'd0);

    // Bubble collapse against a stalled sink.
    OUT_READY = 1'b0;
    IN_VALID = 1'b1; IN_DATA = 8'h01; cycle(1'b1);
    IN_VALID = 1'b0; cycle(1'b1); cycle(1'b1);
    IN_VALID = 1'b1; IN_DATA = 8'h02; cycle(1'b1);
    IN_VALID = 1'b0; cycle(1'b1);
    chk("bubble_occ", OCC, 2'd2);
    chk("bubble_in_ready", IN_READY, 1'b1);
    chk("bubble_head", OUT_DATA, 8'h01);

    // Enable freeze mid-stream; inputs must be ignored.
    En = 1'b0; OUT_READY = 1'b1; IN_VALID = 1'b1;
    for (int i = 0; i < 4; i++) begin
      IN_DATA = 8'($urandom);
      cycle(1'b1);
      chk("freeze_occ", OCC, 2'd2);
      chk("freeze_data", OUT_DATA, 8'h01);
    end
    En = 1'b1; IN_VALID = 1'b0;
    for (int i = 0; i < 6; i++) cycle(1'b1);
    chk("freeze_drained", OCC, 2'd0);

    // Flush a full pipe while upstream is offering a word.
    OUT_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      IN_VALID = 1'b1; IN_DATA = 8'h5A + 8'(i);
      cycle(1'b1);
    end
    chk("flush_full", OCC, 2'd3);
    FLUSH = 1'b1; IN_VALID = 1'b1; IN_DATA = 8'h99;
    cycle(1'b1);
    chk("flush_no_accept", last_acc, 1'b0);
    FLUSH = 1'b0; IN_VALID = 1'b0;
    chk("flush_occ", OCC, 2'd0);
    chk("flush_out_valid", OUT_VALID, 1'b0);
    OUT_READY = 1'b1;
    IN_VALID = 1'b1; IN_DATA = 8'h66; cycle(1'b1);
    IN_VALID = 1'b0; cycle(1'b1); cycle(1'b1);
    chk("flush_next_latency", {OUT_VALID, OUT_DATA}, {1'b1, 8'h66});
    cycle(1'b1);

    // Random traffic with occasional stalls, flushes and resets.
    for (int i = 0; i < 600; i++) begin
      En        = ($urandom_range(0, 9) != 0);
      FLUSH     = ($urandom_range(0, 29) == 0);
      RST       = ($urandom_range(0, 149) == 0);
      IN_VALID  = $urandom_range(0, 1) == 1;
      IN_DATA   = 8'($urandom);
      OUT_READY = ($urandom_range(0, 3) != 0);
      cycle(1'b1);
    end
    RST = 1'b0; En = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
    for (int i = 0; i < 6; i++) cycle(1'b1);
    chk("final_empty", OCC, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
